// File: rtl/pong_text_pkg.sv
// pong_text_pkg: glyph codes, message lengths, FSM encoding and glyph cell size shared by the text overlay
package pong_text_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, BLINK = 2'd2} state_t;

    localparam int GLYPH_W = 26;
    localparam int GLYPH_H = 40;

    localparam logic [4:0] G_A = 5'd0,  G_B = 5'd1,  G_C = 5'd2,  G_D = 5'd3,  G_E = 5'd4;
    localparam logic [4:0] G_F = 5'd5,  G_G = 5'd6,  G_H = 5'd7,  G_I = 5'd8,  G_J = 5'd9;
    localparam logic [4:0] G_K = 5'd10, G_L = 5'd11, G_M = 5'd12, G_N = 5'd13, G_O = 5'd14;
    localparam logic [4:0] G_P = 5'd15, G_Q = 5'd16, G_R = 5'd17, G_S = 5'd18, G_T = 5'd19;
    localparam logic [4:0] G_U = 5'd20, G_V = 5'd21, G_W = 5'd22, G_X = 5'd23, G_Y = 5'd24;
    localparam logic [4:0] G_Z = 5'd25;
    // A 5-bit code leaves room for only five digits after the alphabet; digit d sits at 26+d
    localparam logic [4:0] G_0 = 5'd26, G_1 = 5'd27, G_2 = 5'd28, G_3 = 5'd29, G_4 = 5'd30;
    localparam logic [4:0] G_SPACE = 5'd31;

    function automatic logic [3:0] msg_len(input logic [1:0] id);
        return id == 2'd0 ? 4'd4 : id == 2'd3 ? 4'd9 : 4'd6;
    endfunction

endpackage

// File: rtl/text_msg_rom.sv
// text_msg_rom: maps a message select and character slot to its glyph code
module text_msg_rom
    import pong_text_pkg::*;
(
    input  logic [1:0] msg_id,
    input  logic [3:0] slot,
    output logic [4:0] code
);

    always_comb begin
        code = G_SPACE;
        case ({msg_id, slot})
            6'h00: code = G_P;
            6'h01: code = G_O;
            6'h02: code = G_N;
            6'h03: code = G_G;
            6'h10: code = G_P;
            6'h11: code = G_1;
            6'h13: code = G_W;
            6'h14: code = G_I;
            6'h15: code = G_N;
            6'h20: code = G_P;
            6'h21: code = G_2;
            6'h23: code = G_W;
            6'h24: code = G_I;
            6'h25: code = G_N;
            6'h30: code = G_G;
            6'h31: code = G_A;
            6'h32: code = G_M;
            6'h33: code = G_E;
            6'h35: code = G_O;
            6'h36: code = G_V;
            6'h37: code = G_E;
            6'h38: code = G_R;
            default: code = G_SPACE;
        endcase
    end

endmodule

// File: rtl/text_overlay_ctrl.sv
// text_overlay_ctrl: sequences a one-row text message (steady, then blinking) and maps pixels to glyph cells
module text_overlay_ctrl
    import pong_text_pkg::*;
#(
    parameter logic [9:0] ORIGIN_X      = 10'd224,
    parameter logic [9:0] ORIGIN_Y      = 10'd200,
    parameter int         PITCH         = 32,
    parameter int         SHOW_FRAMES   = 120,
    parameter int         BLINK_FRAMES  = 15,
    parameter int         BLINK_TOGGLES = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       frame_tick,
    input  logic       msg_valid,
    input  logic [1:0] msg_id,
    output logic       msg_ready,
    input  logic       cancel,
    output logic       glyph_en,
    output logic [4:0] glyph_id,
    output logic [9:0] glyph_start_x,
    output logic [9:0] glyph_start_y,
    output logic       busy,
    output logic       done
);

    localparam int SH = $clog2(PITCH);
    localparam int FW = $clog2((SHOW_FRAMES > BLINK_FRAMES ? SHOW_FRAMES : BLINK_FRAMES) + 1);
    localparam int TW = $clog2(BLINK_TOGGLES + 1);

    state_t        state;
    logic [FW-1:0] fcnt;
    logic [TW-1:0] tcnt;
    logic          visible;
    logic [1:0]    id_q;
    logic [9:0]    dx, slot, cell_x;
    logic [4:0]    code;
    logic          hit;

    assign msg_ready = (state == IDLE) && !cancel;
    assign dx        = x - ORIGIN_X;
    assign slot      = dx >> SH;
    assign cell_x    = ORIGIN_X + (slot << SH);

    text_msg_rom u_rom (.msg_id(id_q), .slot(slot[3:0]), .code(code));

    // Slot range is checked before the ROM code is trusted, so only slot[3:0] reaches the ROM
    assign hit = (state != IDLE) && visible && (x >= ORIGIN_X) && (slot < 10'(msg_len(id_q)))
              && ((dx & 10'(PITCH - 1)) < 10'(GLYPH_W)) && (y >= ORIGIN_Y)
              && ({1'b0, y} < 11'(ORIGIN_Y) + 11'(GLYPH_H)) && (code != G_SPACE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            fcnt          <= '0;
            tcnt          <= '0;
            visible       <= 1'b1;
            id_q          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            glyph_en      <= 1'b0;
            glyph_id      <= '0;
            glyph_start_x <= '0;
            glyph_start_y <= '0;
        end else begin
            done          <= 1'b0;
            glyph_en      <= hit;
            glyph_id      <= hit ? code : '0;
            glyph_start_x <= hit ? cell_x : '0;
            glyph_start_y <= hit ? ORIGIN_Y : '0;
            case (state)
                IDLE: if (msg_valid && msg_ready) begin
                    state   <= SHOW;
                    busy    <= 1'b1;
                    id_q    <= msg_id;
                    fcnt    <= '0;
                    tcnt    <= '0;
                    visible <= 1'b1;
                end
                SHOW: if (cancel) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (frame_tick) begin
                    if (fcnt == FW'(SHOW_FRAMES - 1)) begin
                        state   <= BLINK;
                        visible <= 1'b0;
                        fcnt    <= '0;
                        tcnt    <= '0;
                    end else
                        fcnt <= fcnt + 1'b1;
                end
                BLINK: if (cancel) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (frame_tick) begin
                    if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                        fcnt    <= '0;
                        visible <= ~visible;
                        tcnt    <= tcnt + 1'b1;
                        if (tcnt == TW'(BLINK_TOGGLES - 1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else
                        fcnt <= fcnt + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// tb_text_overlay_ctrl: randomized self-checking bench against a tick-count reference model
module tb_text_overlay_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] x = '0, y = '0;
    logic       frame_tick = 1'b0, msg_valid = 1'b0, cancel = 1'b0;
    logic [1:0] msg_id = '0;
    logic       msg_ready, glyph_en, busy, done;
    logic [4:0] glyph_id;
    logic [9:0] glyph_start_x, glyph_start_y;

    text_overlay_ctrl dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .frame_tick(frame_tick),
        .msg_valid(msg_valid), .msg_id(msg_id), .msg_ready(msg_ready), .cancel(cancel),
        .glyph_en(glyph_en), .glyph_id(glyph_id), .glyph_start_x(glyph_start_x),
        .glyph_start_y(glyph_start_y), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    // Model: a message is just "active, which id, how many ticks since acceptance"
    string msgs [4] = '{"PONG", "P1 WIN", "P2 WIN", "GAME OVER"};
    bit m_act, m_done, e_en;
    int m_t, m_id, e_gid, e_sx, e_sy;

    function automatic bit vis(int t);
        return t < 120 || (((t - 120) / 15) % 2 == 1);
    endfunction

    function automatic int code_of(byte ch);
        if (ch == " ") return 31;
        if (ch >= "A" && ch <= "Z") return ch - "A";
        return 26 + (ch - "0");
    endfunction

    task automatic clk_step;
        int dx, slot;
        byte ch;
        e_en = 0; e_gid = 0; e_sx = 0; e_sy = 0;
        if (rst_n && m_act && vis(m_t) && x >= 224 && y >= 200 && y < 240) begin
            dx = int'(x) - 224;
            slot = dx / 32;
            if (slot < msgs[m_id].len() && dx % 32 < 26) begin
                ch = msgs[m_id][slot];
                if (ch != " ") begin
                    e_en = 1; e_gid = code_of(ch); e_sx = 224 + slot * 32; e_sy = 200;
                end
            end
        end
        m_done = 0;
        if (!rst_n) begin
            m_act = 0; m_t = 0;
        end else if (!m_act) begin
            if (msg_valid && !cancel) begin m_act = 1; m_t = 0; m_id = int'(msg_id); end
        end else if (cancel) m_act = 0;
        else if (frame_tick) begin
            m_t++;
            if (m_t == 210) begin m_act = 0; m_done = 1; end
        end
        @(posedge clk); #1;
    endtask

    task automatic run_ticks(int n);
        repeat (n) begin
            frame_tick = 1'b1; clk_step;
            frame_tick = 1'b0; clk_step;
        end
    endtask

    task automatic accept(logic [1:0] id);
        msg_id = id; msg_valid = 1'b1; clk_step;
        msg_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) clk_step;
        checks++;
        if ({glyph_en, glyph_id, glyph_start_x, glyph_start_y, busy, done} !== '0) begin
            errors++; $display("FAIL reset_outputs: got en=%b id=%0d sx=%0d sy=%0d busy=%b done=%b expected all 0",
                glyph_en, glyph_id, glyph_start_x, glyph_start_y, busy, done);
        end
        checks++;
        if (msg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", msg_ready); end
        rst_n = 1'b1;
        clk_step;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy got %b expected 0", busy); end
    endtask

    task automatic test_glyph_map;
        accept(2'd0);
        checks++;
        if (busy !== 1'b1 || msg_ready !== 1'b0) begin
            errors++; $display("FAIL accept: busy=%b ready=%b expected busy=1 ready=0", busy, msg_ready);
        end
        x = 10'(224 + 32 + 3); y = 10'd205; clk_step;
        checks++;
        if (glyph_en !== 1'b1 || glyph_id !== 5'd14 || glyph_start_x !== 10'd256 || glyph_start_y !== 10'd200) begin
            errors++; $display("FAIL glyph_O: got en=%b id=%0d sx=%0d sy=%0d expected en=1 id=14 sx=256 sy=200",
                glyph_en, glyph_id, glyph_start_x, glyph_start_y);
        end
        x = 10'(224 + 26); y = 10'd210; clk_step;
        checks++;
        if (glyph_en !== 1'b0 || glyph_id !== 5'd0 || glyph_start_x !== 10'd0) begin
            errors++; $display("FAIL gap_column: got en=%b id=%0d sx=%0d expected 0", glyph_en, glyph_id, glyph_start_x);
        end
        x = 10'(224 + 4 * 32); clk_step;
        checks++;
        if (glyph_en !== 1'b0 || glyph_id !== 5'd0) begin
            errors++; $display("FAIL slot4: got en=%b id=%0d expected 0", glyph_en, glyph_id);
        end
        x = 10'd100; clk_step;
        checks++;
        if (glyph_en !== 1'b0) begin errors++; $display("FAIL left_of_origin: got en=%b expected 0", glyph_en); end
        cancel = 1'b1; clk_step;
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL cancel_glyph_test: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_full_sequence;
        int cyc, dones, bad;
        dones = 0; bad = 0; cyc = 0;
        accept(2'($urandom_range(0, 3)));
        while (dones == 0 && cyc < 4000) begin
            x = 10'(224 + $urandom_range(0, 320));
            y = 10'(195 + $urandom_range(0, 50));
            frame_tick = ($urandom_range(0, 2) == 0);
            msg_valid = ($urandom_range(0, 7) == 0);
            msg_id = 2'($urandom);
            clk_step;
            cyc++;
            checks++;
            if (glyph_en !== e_en || int'(glyph_id) != e_gid || int'(glyph_start_x) != e_sx
                || int'(glyph_start_y) != e_sy || busy !== m_act || done !== m_done) begin
                errors++; bad++;
                if (bad < 10)
                    $display("FAIL seq_cycle%0d: got en=%b id=%0d sx=%0d sy=%0d busy=%b done=%b expected en=%b id=%0d sx=%0d sy=%0d busy=%b done=%b",
                        cyc, glyph_en, glyph_id, glyph_start_x, glyph_start_y, busy, done,
                        e_en, e_gid, e_sx, e_sy, m_act, m_done);
            end
            if (done === 1'b1) dones++;
        end
        frame_tick = 1'b0; msg_valid = 1'b0;
        checks++;
        if (dones != 1) begin errors++; $display("FAIL seq_done: got %0d done pulses expected 1 within budget", dones); end
        #1;
        checks++;
        if (msg_ready !== 1'b1) begin errors++; $display("FAIL ready_after_done: got %b expected 1", msg_ready); end
        clk_step;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", done); end
    endtask

    task automatic test_cancel;
        accept(2'd3);
        run_ticks(50);
        cancel = 1'b1; msg_valid = 1'b1; msg_id = 2'd1;
        #1;
        checks++;
        if (msg_ready !== 1'b0) begin errors++; $display("FAIL ready_with_cancel: got %b expected 0", msg_ready); end
        clk_step;
        cancel = 1'b0; msg_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL cancel_show: busy=%b done=%b expected 0 0", busy, done);
        end
        clk_step;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL cancel_no_accept: busy=%b done=%b expected 0 0", busy, done);
        end
        cancel = 1'b1; msg_valid = 1'b1; clk_step;
        cancel = 1'b0; msg_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL cancel_idle_block: busy got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid;
        accept(2'd1);
        run_ticks(140);
        msg_valid = 1'b1; msg_id = 2'd3; clk_step;
        msg_valid = 1'b0;
        x = 10'(224 + 32 + 5); y = 10'd210; clk_step;
        checks++;
        if (glyph_en !== e_en || int'(glyph_id) != e_gid || glyph_id !== 5'd27) begin
            errors++; $display("FAIL id_held_busy: got en=%b id=%0d expected en=%b id=%0d (27)", glyph_en, glyph_id, e_en, e_gid);
        end
        rst_n = 1'b0; m_act = 0;
        #1;
        checks++;
        if ({glyph_en, glyph_id, glyph_start_x, glyph_start_y, busy, done} !== '0 || msg_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset: got en=%b id=%0d sx=%0d busy=%b done=%b ready=%b expected zeros ready=1",
                glyph_en, glyph_id, glyph_start_x, busy, done, msg_ready);
        end
        clk_step;
        rst_n = 1'b1;
        frame_tick = 1'b1;
        repeat (3) begin
            clk_step;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || glyph_en !== 1'b0) begin
                errors++; $display("FAIL after_reset: busy=%b done=%b en=%b expected 0 0 0", busy, done, glyph_en);
            end
        end
        frame_tick = 1'b0;
    endtask

    initial begin
        test_reset;
        test_glyph_map;
        test_full_sequence;
        test_cancel;
        test_full_sequence;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
